// File: rtl/sram_controller_pkg.sv
// sram_controller_pkg
//   Shared constants for the data-memory SRAM path: external SRAM geometry,
//   the byte address where data memory starts, and the default wait-state
//   count. Also a helper that turns a CPU byte address into a byte offset
//   inside the SRAM window.
package sram_controller_pkg;

  localparam int SRAM_ADDR_LEN       = 18;
  localparam int SRAM_DATA_LEN       = 16;
  localparam int DATA_MEM_BASE       = 1024;
  localparam int DEFAULT_WAIT_CYCLES = 4;

  // The subtraction is modulo 2^32, so addresses below the base wrap around
  // instead of faulting.
  function automatic logic [31:0] mem_offset(input logic [31:0] address,
                                             input logic [31:0] base);
    return address - base;
  endfunction

endpackage

// File: rtl/sram_controller.sv
// sram_controller
//   Turns one 32-bit MEM-stage load/store into two 16-bit accesses on an
//   asynchronous SRAM: low half first, then high half. Each half takes
//   WAIT_CYCLES clocks. ready drops for the whole access, and the pipeline
//   freezes while it is low.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   rd_en, wr_en       MEM-stage load / store request (the store wins if both are set)
//   address            byte address; bits [1:0] are ignored
//   write_data         store data
//   read_data          registered load data; only a read changes it
//   ready              0 while an access is in progress
//   sram_dq            bidirectional SRAM data bus
//   sram_addr          SRAM half-word address
//   sram_we_n          SRAM write enable (active low)
//   sram_oe_n          SRAM output enable (active low)
//   sram_ce_n/ub_n/lb_n  tied active
//
// State  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for rd_en/wr_en; latches op, word index and data
// LOW    | low half-word access, WAIT_CYCLES clocks
// HIGH   | high half-word access, WAIT_CYCLES clocks
// DONE   | one clock with ready=1 and read_data complete
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int SRAM_ADDR_W = SRAM_ADDR_LEN,
  parameter int BASE_ADDR   = DATA_MEM_BASE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic                     wr_en,
  input  logic [31:0]              address,
  input  logic [31:0]              write_data,
  output logic [31:0]              read_data,
  output logic                     ready,
  inout  wire  [SRAM_DATA_LEN-1:0] sram_dq,
  output logic [SRAM_ADDR_W-1:0]   sram_addr,
  output logic                     sram_we_n,
  output logic                     sram_oe_n,
  output logic                     sram_ce_n,
  output logic                     sram_ub_n,
  output logic                     sram_lb_n
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int               CNT_W    = $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t                   state, nxt;
  logic [CNT_W-1:0]         cnt;
  logic                     op_wr;
  logic [SRAM_ADDR_W-2:0]   word_q;
  logic [31:0]              wdata_q;

  logic                     req;
  logic                     cnt_last;
  logic                     active;
  logic                     phase_hi;
  logic                     drive_dq;
  logic [SRAM_DATA_LEN-1:0] dq_out;
  logic [31:0]              offset;
  logic [SRAM_ADDR_W-2:0]   word_in;
  logic                     unused_offset_bits;

  assign req      = rd_en | wr_en;
  assign cnt_last = (cnt == CNT_LAST);

  // The word index keeps only SRAM_ADDR_W-1 bits, so out-of-range addresses
  // wrap modulo the SRAM size. The byte-lane bits are discarded.
  assign offset             = mem_offset(address, 32'(BASE_ADDR));
  assign word_in            = offset[SRAM_ADDR_W:2];
  assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (req)      nxt = ST_LOW;
      ST_LOW:  if (cnt_last) nxt = ST_HIGH;
      ST_HIGH: if (cnt_last) nxt = ST_DONE;
      ST_DONE:               nxt = ST_IDLE;
      default:               nxt = ST_IDLE;
    endcase
  end

  // Wait counter, request latches and read capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      op_wr     <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
      read_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (req) begin
            op_wr   <= wr_en;
            word_q  <= word_in;
            wdata_q <= write_data;
          end
        end
        ST_LOW, ST_HIGH: begin
          cnt <= cnt_last ? '0 : cnt + 1'b1;
          // Sample on the last wait cycle, when the SRAM access time has been met.
          if (!op_wr && cnt_last) begin
            if (state == ST_LOW) read_data[15:0]  <= sram_dq;
            else                 read_data[31:16] <= sram_dq;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Outputs
  always_comb begin
    active   = (state == ST_LOW) || (state == ST_HIGH);
    phase_hi = (state == ST_HIGH);
    drive_dq = active && op_wr;
    dq_out   = phase_hi ? wdata_q[31:16] : wdata_q[15:0];
    ready    = (state == ST_DONE) || ((state == ST_IDLE) && !req);
    sram_addr = active ? {word_q, phase_hi} : '0;
    // we_n rises on the last wait cycle while dq is still driven, which
    // gives the SRAM its data hold time.
    sram_we_n = !(drive_dq && !cnt_last);
    sram_oe_n = !(active && !op_wr);
    sram_ce_n = 1'b0;
    sram_ub_n = 1'b0;
    sram_lb_n = 1'b0;
  end

  assign sram_dq = drive_dq ? dq_out : {SRAM_DATA_LEN{1'bz}};

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

  localparam int W    = 4;
  localparam int AW   = 18;
  localparam int BASE = 1024;

  logic        clk, rst, rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [AW-1:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  int checks   = 0;
  int failures = 0;

  sram_controller #(.WAIT_CYCLES(W), .SRAM_ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_dq(sram_dq), .sram_addr(sram_addr), .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n), .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM: half-word storage, drives the bus on reads.
  logic [15:0] sram_mem [int unsigned];

  function automatic logic [15:0] sram_fetch(input logic [AW-1:0] a);
    if (sram_mem.exists(32'(a))) return sram_mem[32'(a)];
    return 16'h0000;
  endfunction

  assign sram_dq = (!sram_oe_n && sram_we_n) ? sram_fetch(sram_addr) : 16'hzzzz;

  always @(posedge clk) if (!sram_we_n) sram_mem[32'(sram_addr)] = sram_dq;

  // Reference model: 32-bit words indexed by word number, plus the last read.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] model_rdata;

  function automatic int unsigned ref_word(input logic [31:0] a);
    return ((a - 32'(BASE)) >> 2) % 131072;
  endfunction

  function automatic logic [31:0] ref_read(input int unsigned w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One complete access. Called at posedge+1; returns at posedge+1.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input int unsigned w,
                        input logic [31:0] exp_rd, input logic drop);
    logic [31:0] half;
    rd_en = rd; wr_en = wr; address = addr; write_data = data;
    @(negedge clk);
    check("ready_on_request", {31'd0, ready}, 32'd0);
    for (int p = 0; p < 2; p++) begin
      half = (p == 0) ? {16'h0, data[15:0]} : {16'h0, data[31:16]};
      for (int k = 0; k < W; k++) begin
        @(negedge clk);
        check("ready_busy", {31'd0, ready}, 32'd0);
        check("sram_addr", 32'(sram_addr), 32'((w * 2 + p) % (1 << AW)));
        if (wr) begin
          check("we_n_write", {31'd0, sram_we_n}, (k == W - 1) ? 32'd1 : 32'd0);
          check("oe_n_write", {31'd0, sram_oe_n}, 32'd1);
          check("dq_write", {16'h0, sram_dq}, half);
        end else begin
          check("we_n_read", {31'd0, sram_we_n}, 32'd1);
          check("oe_n_read", {31'd0, sram_oe_n}, 32'd0);
        end
      end
    end
    @(negedge clk);
    check("ready_done", {31'd0, ready}, 32'd1);
    check("read_data_done", read_data, exp_rd);
    check("we_n_done", {31'd0, sram_we_n}, 32'd1);
    check("oe_n_done", {31'd0, sram_oe_n}, 32'd1);
    @(posedge clk); #1;
    if (drop) begin
      rd_en = 0; wr_en = 0;
      @(negedge clk);
      check("ready_after_done", {31'd0, ready}, 32'd1);
      check("read_data_hold", read_data, exp_rd);
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned word;
    logic [31:0] exp_rdata;
    logic        drop;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'd1032,   32'h12345678, 2,      32'h00000000, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 32'd1032,   32'h00000000, 2,      32'h12345678, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 32'd1024,   32'hCAFEF00D, 0,      32'h12345678, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'd1024,   32'h00000000, 0,      32'hCAFEF00D, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 32'd1040,   32'hA5A5A5A5, 4,      32'hCAFEF00D, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 32'd1043,   32'h00000000, 4,      32'hA5A5A5A5, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'd525312, 32'h0BADBEEF, 0,      32'hA5A5A5A5, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'd1024,   32'h00000000, 0,      32'h0BADBEEF, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'd1035,   32'h00000000, 2,      32'h12345678, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'd1020,   32'h13579BDF, 131071, 32'h12345678, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'd1020,   32'h00000000, 131071, 32'h13579BDF, 1'b1};

    rst = 0; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
    model_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_read_data", read_data, 32'h0);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd1);
    rst = 1;
    @(posedge clk); #1;

    // Idle: no request for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, ready}, 32'd1);
      check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
      check("idle_oe_n", {31'd0, sram_oe_n}, 32'd1);
    end
    @(posedge clk); #1;

    // Directed vectors: write/read, back-to-back, conflict, wrap, below base.
    foreach (vecs[i]) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data,
             vecs[i].word, vecs[i].exp_rdata, vecs[i].drop);
      if (vecs[i].wr) ref_mem[vecs[i].word] = vecs[i].data;
      model_rdata = vecs[i].exp_rdata;
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic        r, wv, dr;
      logic [31:0] a, d, e;
      int unsigned w, op;
      op = $urandom_range(0, 2);
      r  = (op != 1);
      wv = (op != 0);
      a  = 32'(BASE) + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) a = a + 32'h0008_0000;
      d  = $urandom;
      dr = 1'($urandom_range(0, 1));
      w  = ref_word(a);
      e  = wv ? model_rdata : ref_read(w);
      access(r, wv, a, d, w, e, dr);
      if (wv) ref_mem[w] = d;
      model_rdata = e;
    end
    rd_en = 0; wr_en = 0;
    @(posedge clk); #1;

    // Reset in the middle of a read (cycle 5).
    rd_en = 1; address = 32'd1032;
    repeat (5) @(posedge clk);
    #2 rst = 0;
    #1;
    check("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("midrst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    check("midrst_read_data", read_data, 32'h0);
    check("midrst_ready_req", {31'd0, ready}, 32'd0);
    rd_en = 0;
    #1;
    check("midrst_ready_idle", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst = 1;
    model_rdata = 0;
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'd1032, 32'h0, ref_word(32'd1032), ref_read(ref_word(32'd1032)), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
